// File: rtl/efuse_trim_shadow.sv
// Captures the efuse autoload image, checks it with CRC-8 over bytes 0..30, and
// drives a registered trim bus with the fuse image, a default image, or a software override.
module efuse_trim_shadow #(
    parameter int           NR           = 64,
    parameter int           TIMEOUT      = 4096,
    parameter int           TMO_W        = 13,
    parameter logic [247:0] DEFAULT_TRIM = 248'h0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pmu_efuse_start,
    input  logic            efuse_autoload_vld,
    input  logic [NR-1:0]   efuse_rdata_w,
    input  logic            efuse_autoload_done,
    input  logic            rg_trim_ovr_en,
    input  logic [247:0]    rg_trim_ovr_data,
    output logic [247:0]    trim_data,
    output logic            trim_valid,
    output logic [1:0]      trim_status,
    output logic            trim_busy
);
    localparam int NWORD = 256 / NR;
    localparam int CNT_W = $clog2(NWORD + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_CHECK   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [4:0]         byte_q, byte_d;
    logic [7:0]         crc_q, crc_d;
    logic [1:0]         status_q, status_d;
    logic [247:0]       trim_q, trim_d;
    logic [255:0]       shadow_q;
    logic               wr_en;
    logic [7:0]         cur_byte;

    // Byte-at-a-time CRC-8 (poly 0x07), MSB first, no reflection.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] din);
        logic [7:0] r;
        r = crc ^ din;
        for (int i = 0; i < 8; i++) begin
            r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
        end
        return r;
    endfunction

    assign cur_byte = shadow_q[8*int'(byte_q) +: 8];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        tmo_d    = tmo_q;
        byte_d   = byte_q;
        crc_d    = crc_q;
        status_d = status_q;
        wr_en    = 1'b0;
        if (pmu_efuse_start) begin
            state_d = S_CAPTURE;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            tmo_d   = '0;
        end else begin
            case (state_q)
                S_CAPTURE: begin
                    tmo_d = tmo_q + 1'b1;
                    if (efuse_autoload_vld) begin
                        if (cnt_q == CNT_W'(NWORD)) begin
                            ovf_d = 1'b1;
                        end else begin
                            wr_en = 1'b1;
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    // done sees the count/overflow already updated by a same-cycle word
                    if (efuse_autoload_done) begin
                        if (cnt_d == CNT_W'(NWORD) && !ovf_d) begin
                            state_d = S_CHECK;
                            byte_d  = '0;
                            crc_d   = '0;
                        end else begin
                            state_d  = S_DONE;
                            status_d = 2'd3;
                        end
                    end else if (tmo_d == TMO_W'(TIMEOUT)) begin
                        state_d  = S_DONE;
                        status_d = 2'd3;
                    end
                end
                S_CHECK: begin
                    if (byte_q != 5'd31) begin
                        crc_d  = crc8_step(crc_q, cur_byte);
                        byte_d = byte_q + 1'b1;
                    end else begin
                        state_d = S_DONE;
                        if (shadow_q == '0)
                            status_d = 2'd1;
                        else if (crc_q == shadow_q[255:248])
                            status_d = 2'd0;
                        else
                            status_d = 2'd2;
                    end
                end
                default: ;
            endcase
        end
    end

    // Loading on state_d keeps trim_data aligned with the rising edge of trim_valid.
    always_comb begin
        trim_d = trim_q;
        if (rg_trim_ovr_en)
            trim_d = rg_trim_ovr_data;
        else if (state_d == S_DONE)
            trim_d = (status_d == 2'd0) ? shadow_q[247:0] : DEFAULT_TRIM;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            tmo_q    <= '0;
            byte_q   <= '0;
            crc_q    <= '0;
            status_q <= 2'd0;
            trim_q   <= DEFAULT_TRIM;
            shadow_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            tmo_q    <= tmo_d;
            byte_q   <= byte_d;
            crc_q    <= crc_d;
            status_q <= status_d;
            trim_q   <= trim_d;
            if (wr_en)
                shadow_q[NR*int'(cnt_q) +: NR] <= efuse_rdata_w;
        end
    end

    assign trim_data   = trim_q;
    assign trim_valid  = (state_q == S_DONE);
    assign trim_status = status_q;
    assign trim_busy   = (state_q == S_CAPTURE) || (state_q == S_CHECK);
endmodule

// File: doc/efuse_trim_shadow.md
Name: efuse_trim_shadow

Overview:
Downstream consumer of efuse_ctrl autoload traffic. It captures the 256-bit fuse image word by word, checks it byte-serially with CRC-8, and classifies it as valid, blank or corrupt. It then drives a registered 248-bit trim bus to the analog and PMU blocks, substituting a default image when the fuse content is unusable. A software override path is provided for bring-up.

Parameters:
NR, 64, autoload word width; must be one of 8/16/32/64/128/256; NWORD = 256/NR.
TIMEOUT, 4096, maximum cycles in CAPTURE before the load is declared failed.
TMO_W, 13, width of the timeout counter; must satisfy 2^TMO_W > TIMEOUT.
DEFAULT_TRIM, 248'h0, trim image applied on blank, CRC error or load error.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
pmu_efuse_start  in  1  one-cycle pulse; arms capture, same pulse that starts efuse_ctrl autoload
efuse_autoload_vld  in  1  one-cycle strobe; efuse_rdata_w is valid
efuse_rdata_w  in  NR  autoload data word, in ascending word order
efuse_autoload_done  in  1  one-cycle pulse; autoload finished
rg_trim_ovr_en  in  1  software override enable
rg_trim_ovr_data  in  248  software override image
trim_data  out  248  registered trim bus
trim_valid  out  1  high once a final image has been selected; stays high until the next start
trim_status  out  2  0=fuse ok, 1=blank->default, 2=CRC error->default, 3=load error->default
trim_busy  out  1  high in CAPTURE or CHECK

Behaviour:
- Reset is asynchronous, active-high. Reset values: trim_data=DEFAULT_TRIM, trim_valid=0, trim_status=0, trim_busy=0, shadow=0, state=IDLE.
- Image layout: word w occupies shadow[NR*w+NR-1 : NR*w]. Byte k is shadow[8k+7:8k]. Bytes 0..30 are payload; byte 31 is the stored CRC.
- States: IDLE, CAPTURE, CHECK, DONE.
- pmu_efuse_start in any state, including CHECK or CAPTURE mid-operation, does the following on the next edge: state=CAPTURE, word count=0, timeout counter=0, overflow flag=0, trim_valid=0. Shadow contents are not cleared. trim_data holds its old value.
- CAPTURE, each efuse_autoload_vld:
  - Word count < NWORD: shadow word[count] <= efuse_rdata_w, and count increments.
  - Word count == NWORD: the word is dropped and the overflow flag is set.
- CAPTURE, efuse_autoload_done: if count == NWORD and overflow == 0, go to CHECK; otherwise go to DONE with status 3.
- vld and done in the same cycle: the word is captured first, then done is evaluated with the updated count.
- The timeout counter increments every CAPTURE cycle. When it reaches TIMEOUT, go to DONE with status 3.
- CHECK:
  - CRC-8, polynomial x^8+x^2+x+1 (0x07), init 0x00, no reflection, no final XOR.
  - One payload byte per cycle, byte 0 first, MSB first within the byte: 31 cycles.
  - On the cycle after byte 30, evaluate in priority order:
    - All 256 shadow bits are zero: status 1.
    - CRC equals byte 31: status 0.
    - Otherwise: status 2.
  - Then go to DONE.
- DONE: trim_valid=1. The selected image is shadow[247:0] when status=0, else DEFAULT_TRIM. The state holds until the next start.
- trim_data is registered every cycle:
  - rg_trim_ovr_en=1 (in any state): rg_trim_ovr_data.
  - Else in DONE: the selected image.
  - Else: holds its value.
  - Override takes effect 1 cycle after assertion; the override does not affect trim_valid or trim_status.
- efuse_autoload_vld and efuse_autoload_done outside CAPTURE are ignored.
- Latency: done to trim_valid is 33 cycles on the CHECK path (1 to enter CHECK, 31 CRC cycles, 1 evaluate) and 1 cycle on the error path.

Test Plan:
- Good image: start, then 4 vld words with word3=64'h0701_0000_0000_0000 and words 0-2 = 0, then done. Required: trim_busy for 33 cycles, trim_status=0, trim_valid=1, trim_data[247:240]=8'h01, all other trim_data bits 0.
- CRC mismatch: same image but byte31=8'hF2 instead of 8'hF3 with byte30=8'hFF. Required: status=2, trim_data=DEFAULT_TRIM, trim_valid=1.
- Blank: four zero words, then done. Required: status=1, trim_data=DEFAULT_TRIM.
- Short/long load:
  - 3 words then done: status=3 one cycle after done.
  - 5 words then done: fifth word dropped, status=3.
- Timeout: start with no done for 4096 cycles. Required: status=3 and trim_busy=0 exactly at cycle 4096.
- Restart and override:
  - Start pulse during CHECK: trim_valid drops, and a new 4-word good load completes with status 0.
  - rg_trim_ovr_en=1 with ovr_data=248'hA5: trim_data=248'hA5 next cycle.
  - Deassert override: trim_data returns to the selected image.
